// File: rtl/addsub_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : addsub_ctrl_if
// Description : Bundles the request port, the addsub operand/result wires
//               and the result port of addsub_ctrl. The controller uses the
//               slave modport; the sequencer/addsub side uses master.
// Revision    : 1.0 - initial release
// ============================================================================
interface addsub_ctrl_if;
  // Request side
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_sub;
  // addsub operand / result wires
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] add_result;
  logic        add_done;
  logic        add_overflow;
  // Result side
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_ovf;
  logic        res_tmo;

  modport slave (
    input  req_valid, req_a, req_b, req_sub,
    input  add_result, add_done, add_overflow,
    input  res_ready,
    output req_ready, op1, op2,
    output res_valid, res_data, res_ovf, res_tmo
  );

  modport master (
    output req_valid, req_a, req_b, req_sub,
    output add_result, add_done, add_overflow,
    output res_ready,
    input  req_ready, op1, op2,
    input  res_valid, res_data, res_ovf, res_tmo
  );
endinterface
`default_nettype wire

// File: rtl/addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : addsub_ctrl
// Description : Request-side controller for the floating-point addsub unit.
//               Launches registered operands (with the subtract sign flip),
//               qualifies add_done against a settle window and a timeout,
//               and presents result/overflow/timeout on a valid/ready port.
//               Optional macro ADDSUB_ZERO_BYPASS_EN: requests with a zero
//               exponent operand complete without launching addsub.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_ctrl #(
  parameter int MIN_WAIT = 2,
  parameter int TIMEOUT  = 64
) (
  input  wire logic     clk,
  input  wire logic     n_rst,
  addsub_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [CNT_W-1:0] C_CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_MIN_WAIT = CNT_W'(MIN_WAIT);
  localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [31:0]      op1_q,       op1_d;
  logic [31:0]      op2_q,       op2_d;
  logic [31:0]      res_data_q,  res_data_d;
  logic             res_ovf_q,   res_ovf_d;
  logic             res_tmo_q,   res_tmo_d;
  logic             res_valid_q, res_valid_d;

  logic [31:0]      eff_b;
  logic             done_qual;

  // B with the subtract sign flip applied; used for launch and bypass
  assign eff_b     = {bus.req_b[31] ^ bus.req_sub, bus.req_b[30:0]};
  // A done level only counts once the settle window has elapsed
  assign done_qual = bus.add_done && (cnt_q >= C_MIN_WAIT);

  // State register: all controller flops, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_tmo_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_tmo_q   <= res_tmo_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Next-state logic: launch, settle/timeout qualification, result hold
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_tmo_d   = res_tmo_q;
    res_valid_d = res_valid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
`ifdef ADDSUB_ZERO_BYPASS_EN
          if ((bus.req_a[30:23] == 8'd0) || (bus.req_b[30:23] == 8'd0)) begin
            // Zero operand: answer directly, addsub operands left untouched
            if ((bus.req_a[30:23] == 8'd0) && (bus.req_b[30:23] == 8'd0)) begin
              res_data_d = 32'h0000_0000;
            end else if (bus.req_a[30:23] == 8'd0) begin
              res_data_d = eff_b;
            end else begin
              res_data_d = bus.req_a;
            end
            res_ovf_d   = 1'b0;
            res_tmo_d   = 1'b0;
            res_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            op1_d   = bus.req_a;
            op2_d   = eff_b;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
`else
          op1_d   = bus.req_a;
          op2_d   = eff_b;
          cnt_d   = '0;
          state_d = S_WAIT;
`endif
        end
      end

      S_WAIT: begin
        cnt_d = (cnt_q == C_CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        // Done takes priority over a coincident timeout
        if (done_qual || (cnt_q == C_TMO_LAST)) begin
          res_data_d  = bus.add_result;
          res_ovf_d   = bus.add_overflow;
          res_tmo_d   = !done_qual;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end

      S_HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // Output logic: flop outputs, req_ready decoded from state only
  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.op1       = op1_q;
    bus.op2       = op2_q;
    bus.res_valid = res_valid_q;
    bus.res_data  = res_data_q;
    bus.res_ovf   = res_ovf_q;
    bus.res_tmo   = res_tmo_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_ctrl
// Description : Self-checking bench for addsub_ctrl with a small addsub
//               model and a scoreboard queue of expected results. Runs the
//               zero-bypass case when ADDSUB_ZERO_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_ctrl;

  localparam int MIN_WAIT = 2;
  localparam int TIMEOUT  = 8;

  logic clk;
  logic n_rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   done_mode;   // 0: model (done 1 cycle after op change), 1: tied 1, 2: tied 0
  logic [63:0] prev_ops;
  logic [32:0] model_out;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic        tmo;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  addsub_ctrl_if bus();

  addsub_ctrl #(
    .MIN_WAIT (MIN_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter and previous-operand register for the addsub model
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_ops <= {bus.op1, bus.op2};
  end

  // Known sums for the operand pairs the bench launches; bit 32 = overflow
  function automatic logic [32:0] fp_model(input logic [31:0] x, input logic [31:0] y);
    case ({x, y})
      64'h40200000_40600000: return {1'b0, 32'h40C00000};
      64'h40840000_C0800000: return {1'b0, 32'h3E000000};
      64'h40300000_40300000: return {1'b0, 32'h40B00000};
      64'hC6000000_45800000: return {1'b0, 32'hC5800000};
      64'h7F000000_7F000000: return {1'b1, 32'h7F800000};
      default:               return {1'b0, 32'hDEADBEEF};
    endcase
  endfunction

  assign model_out        = (done_mode == 2) ? {1'b0, 32'h12345678} : fp_model(bus.op1, bus.op2);
  assign bus.add_result   = model_out[31:0];
  assign bus.add_overflow = model_out[32];
  assign bus.add_done     = (done_mode == 1) ||
                            ((done_mode == 0) && ({bus.op1, bus.op2} == prev_ops));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request through the controller; lat = edges from acceptance to res_valid
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] exp_op1, input logic [31:0] exp_op2,
                        input logic [31:0] exp_data, input logic exp_ovf,
                        input logic exp_tmo, input int exp_lat, input int hold);
    exp_t e;
    int   acc;
    bit   got;
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_sub   = sub;
    bus.req_valid = 1'b1;
    tick();
    acc           = cyc;
    bus.req_valid = 1'b0;
    e.data = exp_data;
    e.ovf  = exp_ovf;
    e.tmo  = exp_tmo;
    e.lat  = exp_lat;
    sb_q.push_back(e);
    chk("op1", bus.op1, exp_op1);
    chk("op2", bus.op2, exp_op2);
    got = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.res_valid) begin
        got = 1;
        break;
      end
      chk("req_ready_busy", bus.req_ready, 0);
      tick();
    end
    if (!got) begin
      chk("res_valid_never", 0, 1);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      chk("latency", cyc - acc, e.lat);
      chk("res_data", bus.res_data, e.data);
      chk("res_ovf", bus.res_ovf, e.ovf);
      chk("res_tmo", bus.res_tmo, e.tmo);
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("hold_valid", bus.res_valid, 1);
        chk("hold_data", bus.res_data, e.data);
        chk("hold_tmo", bus.res_tmo, e.tmo);
        chk("hold_req_ready", bus.req_ready, 0);
      end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk("valid_drop", bus.res_valid, 0);
      chk("ready_back", bus.req_ready, 1);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_op1", bus.op1, 0);
    chk("rst_op2", bus.op2, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_ovf", bus.res_ovf, 0);
    chk("rst_res_tmo", bus.res_tmo, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc           = 0;
    n_tests       = 0;
    n_fail        = 0;
    done_mode     = 0;
    n_rst         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = 1'b0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    chk_reset_outputs();
    tick();

    // Add: 2.5 + 3.5 = 6.0
    run_op(32'h40200000, 32'h40600000, 1'b0, 32'h40200000, 32'h40600000,
           32'h40C00000, 1'b0, 1'b0, MIN_WAIT + 1, 0);
    // Sub: 4.125 - 4.0 = 0.125
    run_op(32'h40840000, 32'h40800000, 1'b1, 32'h40840000, 32'hC0800000,
           32'h3E000000, 1'b0, 1'b0, MIN_WAIT + 1, 0);
    // Overflow flag passes through
    run_op(32'h7F000000, 32'h7F000000, 1'b0, 32'h7F000000, 32'h7F000000,
           32'h7F800000, 1'b1, 1'b0, MIN_WAIT + 1, 0);

    // Stale done level: capture must still wait MIN_WAIT+1 edges
    done_mode = 1;
    run_op(32'h40300000, 32'h40300000, 1'b0, 32'h40300000, 32'h40300000,
           32'h40B00000, 1'b0, 1'b0, MIN_WAIT + 1, 0);
    run_op(32'hC6000000, 32'h45800000, 1'b0, 32'hC6000000, 32'h45800000,
           32'hC5800000, 1'b0, 1'b0, MIN_WAIT + 1, 0);

    // Timeout with 5 cycles of result backpressure
    done_mode = 2;
    run_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 32'h3F800000,
           32'h12345678, 1'b0, 1'b1, TIMEOUT, 5);

    // Reset during WAIT discards the op
    done_mode     = 0;
    bus.req_a     = 32'h40200000;
    bus.req_b     = 32'h40600000;
    bus.req_sub   = 1'b0;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("mid_wait_ready", bus.req_ready, 0);
    tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk_reset_outputs();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("no_result_after_rst", bus.res_valid, 0);
    end

    // Normal op after reset
    run_op(32'h40200000, 32'h40600000, 1'b0, 32'h40200000, 32'h40600000,
           32'h40C00000, 1'b0, 1'b0, MIN_WAIT + 1, 0);

`ifdef ADDSUB_ZERO_BYPASS_EN
    // Zero A, subtract: result is -B on the acceptance edge, operands unchanged
    run_op(32'h00000000, 32'h41480000, 1'b1, 32'h40200000, 32'h40600000,
           32'hC1480000, 1'b0, 1'b0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
